sync_rr_pkt_arb: RTL and testbench

//  Clocked M-to-1 round-robin packet arbiter. It shares one output resource (a synchronous
//  NoC boundary port or a test-harness injector) among MR requesters. The grant is held for a

---
 rtl/sync_rr_pkt_arb.sv | 160 ++++++++++++++++
 tb/tb_sync_rr_pkt_arb.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sync_rr_pkt_arb.sv
// Clocked M-to-1 round-robin packet arbiter; grant held from first flit until tail handshake.
// Optional watchdog forced release is enabled by defining ARB_WDOG_EN.

module sync_rr_pkt_arb #(
  parameter int unsigned MR     = 4,
  parameter int unsigned WDOG_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MR-1:0]         req,
  input  logic [MR-1:0]         eop,
  input  logic                  out_ack,
  output logic [MR-1:0]         gnt,
  output logic [$clog2(MR)-1:0] gnt_id,
  output logic                  busy,
  output logic                  wdog_err
);

  localparam int unsigned IdW = $clog2(MR);

  if (MR < 2 || WDOG_W < 1) begin : g_param_check
    $error("sync_rr_pkt_arb: MR must be >= 2 and WDOG_W >= 1");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [MR-1:0]    gnt_q, gnt_d;
  logic [IdW-1:0]   gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic             wdog_err_q, wdog_err_d;
  logic             wdog_fire;

  // Returns {found, index} of the first set bit after p, wrapping, with p itself searched last.
  function automatic logic [IdW:0] rr_pick(input logic [MR-1:0] r, input logic [IdW-1:0] p);
    logic           found;
    logic [IdW-1:0] idx;
    int unsigned    j;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= MR; k++) begin
      j = (int'(p) + k) % MR;
      if (!found && r[j]) begin
        found = 1'b1;
        idx   = j[IdW-1:0];
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [MR-1:0] to_onehot(input logic [IdW-1:0] idx);
    logic [MR-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

`ifdef ARB_WDOG_EN
  logic [WDOG_W-1:0] cnt_q, cnt_d;

  assign wdog_fire = (state_q == StGrant) && (&cnt_q) && !out_ack;

  // Any change of grant (new owner or release to idle) restarts the count.
  always_comb begin
    cnt_d = '0;
    if (state_q == StGrant && !out_ack && (gnt_d == gnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign wdog_fire = 1'b0;
`endif

  logic [IdW:0]  pick;
  logic [MR-1:0] req_masked;
  logic          release_own;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    busy_d      = busy_q;
    wdog_err_d  = 1'b0;
    req_masked  = req;
    release_own = 1'b0;
    pick        = '0;

    unique case (state_q)
      StIdle: begin
        pick = rr_pick(req, ptr_q);
        if (pick[IdW]) begin
          state_d  = StGrant;
          ptr_d    = pick[IdW-1:0];
          gnt_d    = to_onehot(pick[IdW-1:0]);
          gnt_id_d = pick[IdW-1:0];
          busy_d   = 1'b1;
        end
      end
      StGrant: begin
        release_own = (out_ack && eop[gnt_id_q]) || !req[gnt_id_q] || wdog_fire;
        if (release_own) begin
          // The releasing owner is excluded so it cannot win its own release cycle.
          req_masked = req & ~to_onehot(gnt_id_q);
          pick       = rr_pick(req_masked, ptr_q);
          wdog_err_d = wdog_fire;
          if (pick[IdW]) begin
            ptr_d    = pick[IdW-1:0];
            gnt_d    = to_onehot(pick[IdW-1:0]);
            gnt_id_d = pick[IdW-1:0];
          end else begin
            state_d  = StIdle;
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d  = StIdle;
        gnt_d    = '0;
        gnt_id_d = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= IdW'(MR - 1);
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      wdog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;
  assign wdog_err = wdog_err_q;

endmodule

// File: tb/tb_sync_rr_pkt_arb.sv
// Directed bench for sync_rr_pkt_arb (MR=4, WDOG_W=3); watchdog case selected by ARB_WDOG_EN.

module tb_sync_rr_pkt_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] eop;
  logic       out_ack;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       wdog_err;

  int n_cmp = 0;
  int n_err = 0;

  sync_rr_pkt_arb #(
    .MR     (4),
    .WDOG_W (3)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .eop      (eop),
    .out_ack  (out_ack),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .wdog_err (wdog_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full check of the grant outputs; gnt_id is only meaningful while busy.
  task automatic check_gnt(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                           input logic exp_busy);
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    check({tag, ".id"}, 32'(gnt_id), 32'(exp_id));
    check({tag, ".onehot"}, 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] e, input logic a);
    req     = r;
    eop     = e;
    out_ack = a;
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    check_gnt("reset", 4'b0000, 2'd0, 1'b0);
    check("reset.wdog", 32'(wdog_err), 32'd0);

    // 1) First grant from idle
    drive(4'b1010, 4'b0000, 1'b0);
    tick();
    check_gnt("t1", 4'b0010, 2'd1, 1'b1);

    // 2) Back-to-back rotation on tail handshakes
    drive(4'b1111, 4'b0010, 1'b1);
    tick();
    check_gnt("t2a", 4'b0100, 2'd2, 1'b1);
    drive(4'b1111, 4'b0100, 1'b1);
    tick();
    check_gnt("t2b", 4'b1000, 2'd3, 1'b1);
    drive(4'b1111, 4'b1000, 1'b1);
    tick();
    check_gnt("t2c", 4'b0001, 2'd0, 1'b1);

    // out_ack without eop keeps the grant
    drive(4'b1111, 4'b0000, 1'b1);
    tick();
    check_gnt("ack_no_eop", 4'b0001, 2'd0, 1'b1);

    drive(4'b1111, 4'b0001, 1'b1);
    tick();
    check_gnt("to_own1", 4'b0010, 2'd1, 1'b1);
    drive(4'b1111, 4'b0010, 1'b1);
    tick();
    check_gnt("to_own2", 4'b0100, 2'd2, 1'b1);

    // 3) eop without out_ack holds, then sole requester re-granted via idle
    drive(4'b1111, 4'b0100, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold.gnt", 32'(gnt), 32'h4);
    end
    drive(4'b0100, 4'b0100, 1'b1);
    tick();
    check_gnt("t3_idle", 4'b0000, 2'd0, 1'b0);
    drive(4'b0100, 4'b0000, 1'b0);
    tick();
    check_gnt("t3_regrant", 4'b0100, 2'd2, 1'b1);

    // Releasing owner excluded: 2 -> 0 (3 not requesting)
    drive(4'b0101, 4'b0100, 1'b1);
    tick();
    check_gnt("to_own0", 4'b0001, 2'd0, 1'b1);

    // 4) Abort release when owner drops req
    drive(4'b0110, 4'b0000, 1'b0);
    tick();
    check_gnt("t4_abort", 4'b0010, 2'd1, 1'b1);

    drive(4'b1010, 4'b0010, 1'b1);
    tick();
    check_gnt("to_own3", 4'b1000, 2'd3, 1'b1);

    // 5) Reset mid-packet, pointer back to MR-1
    rst = 1'b1;
    drive(4'b1000, 4'b0000, 1'b0);
    tick();
    rst = 1'b0;
    check_gnt("t5_rst", 4'b0000, 2'd0, 1'b0);
    check("t5_rst.wdog", 32'(wdog_err), 32'd0);
    drive(4'b1001, 4'b0000, 1'b0);
    tick();
    check_gnt("t5_after", 4'b0001, 2'd0, 1'b1);

    // 6) Stalled owner 1
    drive(4'b0011, 4'b0001, 1'b1);
    tick();
    check_gnt("t6_grant", 4'b0010, 2'd1, 1'b1);
    drive(4'b0011, 4'b0000, 1'b0);
`ifdef ARB_WDOG_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t6_wait.gnt", 32'(gnt), 32'h2);
      check("t6_wait.wdog", 32'(wdog_err), 32'd0);
    end
    tick();
    check_gnt("t6_forced", 4'b0001, 2'd0, 1'b1);
    check("t6_forced.wdog", 32'(wdog_err), 32'd1);
    tick();
    check("t6_after.wdog", 32'(wdog_err), 32'd0);
    check("t6_after.gnt", 32'(gnt), 32'h1);
`else
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t6_hold.gnt", 32'(gnt), 32'h2);
      check("t6_hold.wdog", 32'(wdog_err), 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
